// File: rtl/adder_3input_pkg.sv
// Shared types for the 3-input adder arbiter: requester-id width helper and id type.
// No logic; imported by the arbiter and the top.
package adder_3input_pkg;

   localparam int MAX_REQ = 16;

   function automatic int id_width(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   // Sized for the largest legal NUM_REQ; narrowed to the port width at the top.
   typedef logic [id_width(MAX_REQ)-1:0] req_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first valid requester at or after ptr, wrapping; combinational.
// Latency 0; no backpressure of its own, grant is always qualified by req.
module rr_arbiter
   import adder_3input_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  req_id_t      ptr,
   output logic [N-1:0] gnt,
   output req_id_t      gnt_idx
);

   logic found;

   // Pass one looks at or above the pointer; pass two only runs if that found nothing,
   // so its first hit is the wrapped-around winner below the pointer.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int j = 0; j < N; j++) begin
         if (!found && req[j] && (req_id_t'(j) >= ptr)) begin
            found   = 1'b1;
            gnt[j]  = 1'b1;
            gnt_idx = req_id_t'(j);
         end
      end
      for (int j = 0; j < N; j++) begin
         if (!found && req[j]) begin
            found   = 1'b1;
            gnt[j]  = 1'b1;
            gnt_idx = req_id_t'(j);
         end
      end
   end

endmodule

// File: rtl/adder_3input_arbiter.sv
// One shared 3-input adder behind a round-robin arbiter; one accept per cycle.
// Latency LATENCY cycles accept-to-result; no output backpressure, inputs stall via req_ready.
module adder_3input_arbiter
   import adder_3input_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int NUM_REQ = 4,   // 1..16
   parameter int LATENCY = 2    // 1..4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]          req_in0,
   input  logic [NUM_REQ*WIDTH-1:0]          req_in1,
   input  logic [NUM_REQ*WIDTH-1:0]          req_in2,
   output logic                              out_valid,
   output logic [id_width(NUM_REQ)-1:0]      out_id,
   output logic [WIDTH-1:0]                  out_data
);

   localparam int IDW = id_width(NUM_REQ);

   req_id_t            ptr;
   logic [NUM_REQ-1:0] gnt;
   req_id_t            gnt_idx;
   logic               xfer;
   logic [WIDTH-1:0]   sum;

   logic [LATENCY-1:0] vld_q;
   req_id_t            id_q  [LATENCY];
   logic [WIDTH-1:0]   dat_q [LATENCY];

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req     (req_valid),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign req_ready = gnt;
   assign xfer      = |gnt;

   // gnt is one-hot, so the operand mux is a plain AND-OR over requesters.
   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sum = req_in0[i*WIDTH +: WIDTH] + req_in1[i*WIDTH +: WIDTH] + req_in2[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (xfer) begin
         ptr <= (gnt_idx == req_id_t'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Stages only load when a valid arrives, so the last stage holds its
   // id/data between results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int k = 0; k < LATENCY; k++) begin
            id_q[k]  <= '0;
            dat_q[k] <= '0;
         end
      end else begin
         vld_q[0] <= xfer;
         if (xfer) begin
            id_q[0]  <= gnt_idx;
            dat_q[0] <= sum;
         end
         for (int k = 1; k < LATENCY; k++) begin
            vld_q[k] <= vld_q[k-1];
            if (vld_q[k-1]) begin
               id_q[k]  <= id_q[k-1];
               dat_q[k] <= dat_q[k-1];
            end
         end
      end
   end

   assign out_valid = vld_q[LATENCY-1];
   assign out_id    = id_q[LATENCY-1][IDW-1:0];
   assign out_data  = dat_q[LATENCY-1];

endmodule

// File: tb/tb_adder_3input_arbiter.sv
// Bench for adder_3input_arbiter: directed vectors, literal expectations plus a
// queue-based reference model compared every cycle at the falling edge.
module tb_adder_3input_arbiter;

   localparam int W   = 16;
   localparam int N   = 4;
   localparam int LAT = 2;

   logic           clk;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_in0, req_in1, req_in2;
   logic           out_valid;
   logic [1:0]     out_id;
   logic [W-1:0]   out_data;

   int total = 0;
   int bad   = 0;

   adder_3input_arbiter #(.WIDTH(W), .NUM_REQ(N), .LATENCY(LAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_in0   (req_in0),
      .req_in1   (req_in1),
      .req_in2   (req_in2),
      .out_valid (out_valid),
      .out_id    (out_id),
      .out_data  (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic setop(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
      req_in0[i*W +: W] = a;
      req_in1[i*W +: W] = b;
      req_in2[i*W +: W] = c;
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int due;
      int id;
      int dat;
   } res_t;

   res_t q[$];
   int   mptr     = 0;
   int   cyc      = 0;
   int   last_id  = 0;
   int   last_dat = 0;

   always @(negedge clk) begin
      int   exp_gnt;
      int   sel;
      logic exp_vld;
      cyc++;
      if (!rst_n) begin
         q.delete();
         mptr     = 0;
         last_id  = 0;
         last_dat = 0;
      end
      exp_vld = 1'b0;
      if (rst_n && q.size() > 0 && q[0].due == cyc) begin
         exp_vld  = 1'b1;
         last_id  = q[0].id;
         last_dat = q[0].dat;
         void'(q.pop_front());
      end
      chk("m_out_valid", 32'(out_valid), 32'(exp_vld));
      chk("m_out_id", 32'(out_id), 32'(last_id));
      chk("m_out_data", 32'(out_data), 32'(last_dat));

      sel = -1;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (mptr + k) % N;
         if (sel < 0 && req_valid[j]) sel = j;
      end
      exp_gnt = (sel < 0) ? 0 : (1 << sel);
      chk("m_req_ready", 32'(req_ready), 32'(exp_gnt));
      if (rst_n && sel >= 0) begin
         res_t r;
         r.due = cyc + LAT;
         r.id  = sel;
         r.dat = (int'(req_in0[sel*W +: W]) + int'(req_in1[sel*W +: W]) + int'(req_in2[sel*W +: W])) % (1 << W);
         q.push_back(r);
         mptr = (sel + 1) % N;
      end
   end

   // ---------------- directed stimulus ----------------
   typedef struct {
      logic [N-1:0] v;
      logic [W-1:0] a;
   } vec_t;

   initial begin
      vec_t tbl [12];
      int   pulses;
      int   got_id;
      int   got_dat;

      rst_n     = 1'b0;
      req_valid = '0;
      req_in0   = '0;
      req_in1   = '0;
      req_in2   = '0;

      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_out_id", 32'(out_id), 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;

      // single requester 2, operands 1,2,3
      req_valid = 4'b0100; setop(2, 16'd1, 16'd2, 16'd3);
      @(negedge clk); chk("r2_ready", 32'(req_ready), 32'h4);
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk); chk("r2_not_yet", 32'(out_valid), 32'h0);
      @(negedge clk);
      chk("r2_valid", 32'(out_valid), 32'h1);
      chk("r2_id", 32'(out_id), 32'h2);
      chk("r2_data", 32'(out_data), 32'h6);

      // wraparound of the sum
      @(posedge clk); #1;
      setop(0, 16'hFFFF, 16'hFFFF, 16'h0003); req_valid = 4'b0001;
      @(negedge clk); chk("wrap_ready", 32'(req_ready), 32'h1);
      @(posedge clk); #1 req_valid = '0;
      repeat (2) @(negedge clk);
      chk("wrap_data", 32'(out_data), 32'h0001);
      chk("wrap_id", 32'(out_id), 32'h0);

      // pointer to 2, then requests 1 and 3 held until granted
      @(posedge clk); #1 setop(1, 16'd5, 16'd6, 16'd7); setop(3, 16'd100, 16'd200, 16'd300); req_valid = 4'b0010;
      @(negedge clk); chk("p2_ready", 32'(req_ready), 32'h2);
      @(posedge clk); #1 req_valid = 4'b1010;
      @(negedge clk); chk("rr_first3", 32'(req_ready), 32'h8);
      @(posedge clk); #1 req_valid = 4'b0010;
      @(negedge clk); chk("rr_then1", 32'(req_ready), 32'h2);
      @(posedge clk); #1 req_valid = 4'b1111;
      @(negedge clk); chk("rr_ptr_back2", 32'(req_ready), 32'h4);
      @(posedge clk); #1 req_valid = '0;
      repeat (3) @(negedge clk);

      // all four continuously valid from reset
      @(posedge clk); #1 rst_n = 1'b0;
      for (int i = 0; i < N; i++) setop(i, W'(16'h1000 * (i + 1)), W'(i), W'(16'h0010));
      req_valid = 4'b1111;
      @(posedge clk); #1 rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("stream_ready", 32'(req_ready), 32'(1 << (k % 4)));
         if (k >= 2) begin
            chk("stream_valid", 32'(out_valid), 32'h1);
            chk("stream_id", 32'(out_id), 32'((k - 2) % 4));
         end
      end
      @(posedge clk); #1 req_valid = '0;
      repeat (3) @(negedge clk);

      // reset one cycle after an accept discards the result
      @(posedge clk); #1 setop(1, 16'd9, 16'd9, 16'd9); req_valid = 4'b0010;
      @(negedge clk); chk("mid_ready", 32'(req_ready), 32'h2);
      @(posedge clk); #1 req_valid = '0; rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", 32'(out_valid), 32'h0);
      chk("mid_rst_data", 32'(out_data), 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      chk("mid_no_pulse", 32'(pulses), 32'h0);
      @(posedge clk); #1 req_valid = 4'b1001;
      @(negedge clk); chk("mid_ptr0", 32'(req_ready), 32'h1);
      @(posedge clk); #1 req_valid = '0;
      repeat (3) @(negedge clk);

      // req 0 drops before grant while req 1 is granted
      @(posedge clk); #1 setop(1, 16'd10, 16'd20, 16'd30); req_valid = 4'b0011;
      @(negedge clk); chk("drop_ready", 32'(req_ready), 32'h2);
      @(posedge clk); #1 req_valid = '0;
      pulses = 0; got_id = -1; got_dat = -1;
      repeat (4) begin
         @(negedge clk);
         if (out_valid) begin
            pulses++;
            got_id  = int'(out_id);
            got_dat = int'(out_data);
         end
      end
      chk("drop_pulses", 32'(pulses), 32'h1);
      chk("drop_id", 32'(got_id), 32'h1);
      chk("drop_data", 32'(got_dat), 32'd60);

      // mixed patterns, model-checked
      tbl[0]  = '{4'b1111, 16'h8001}; tbl[1]  = '{4'b0101, 16'h7FFF};
      tbl[2]  = '{4'b1000, 16'h0123}; tbl[3]  = '{4'b0000, 16'h0000};
      tbl[4]  = '{4'b0110, 16'hFFFE}; tbl[5]  = '{4'b1001, 16'h4444};
      tbl[6]  = '{4'b0011, 16'h00FF}; tbl[7]  = '{4'b1110, 16'hA5A5};
      tbl[8]  = '{4'b0001, 16'h5555}; tbl[9]  = '{4'b1100, 16'hC000};
      tbl[10] = '{4'b0000, 16'h1111}; tbl[11] = '{4'b1111, 16'hFFFF};
      for (int t = 0; t < 12; t++) begin
         @(posedge clk); #1;
         for (int i = 0; i < N; i++) setop(i, tbl[t].a, W'(tbl[t].a + W'(i)), W'(16'h3000 + i));
         req_valid = tbl[t].v;
      end
      @(posedge clk); #1 req_valid = '0;
      repeat (LAT + 2) @(negedge clk);
      chk("drain_empty", 32'(q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

endmodule

// File: doc/adder_3input_arbiter.md
ADDER_3INPUT_ARBITER -- requirements
Module: adder_3input_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and result width in bits.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters, legal range 1..16.
REQ-003 SHALL have parameter LATENCY, default 2, accept-to-result cycles, legal range 1..4.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester operand-valid.
REQ-007 SHALL have port req_ready  output  NUM_REQ  per-requester grant/accept.
REQ-008 SHALL have ports req_in0, req_in1, req_in2  input  NUM_REQ*WIDTH each  operands; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port out_valid  output  1  result valid, single-cycle pulse per result.
REQ-010 SHALL have port out_id  output  max(1,$clog2(NUM_REQ))  index of requester owning the result.
REQ-011 SHALL have port out_data  output  WIDTH  result.

Function
REQ-012 SHALL share one 3-input adder among requesters, accepting at most one request per cycle.
REQ-013 SHALL assert req_ready for at most one requester per cycle, and only for a requester whose req_valid is high that cycle (combinational from req_valid and pointer).
REQ-014 SHALL select the granted requester round-robin: first valid requester at or after pointer, searching upward with wrap from NUM_REQ-1 to 0.
REQ-015 SHALL, on a transfer (req_valid[i] and req_ready[i]), set pointer to i+1, wrapping to 0 after NUM_REQ-1; pointer SHALL be unchanged on cycles without a transfer.
REQ-016 SHALL compute out_data = (in0 + in1 + in2) mod 2^WIDTH; carries beyond WIDTH discarded, no saturation, no overflow flag.
REQ-017 SHALL present a result accepted at rising edge N with out_valid high during cycle N+LATENCY, exactly one cycle, with matching out_id.
REQ-018 SHALL sustain one result per cycle when requests are continuous; results SHALL emerge in acceptance order.
REQ-019 SHALL have no output backpressure; every accepted request produces exactly one result.
REQ-020 SHALL hold out_data and out_id at their last values while out_valid is low.
REQ-021 SHALL tolerate requesters holding req_valid and operands stable until req_ready; a requester dropping req_valid before grant SHALL lose no state and produce no result.
REQ-022 SHALL, with a single requester continuously valid, grant it every cycle; with NUM_REQ=1, req_ready[0] SHALL equal req_valid[0].

Reset
REQ-023 SHALL, while rst_n is low, force out_valid=0, out_data=0, out_id=0, pointer=0 and all pipeline-stage valid bits to 0.
REQ-024 SHALL discard all in-flight results when rst_n asserts mid-operation; no out_valid pulse for them after release.
REQ-025 SHALL accept requests on the first rising edge after rst_n deasserts, with req_ready still gated by req_valid.

Structure
REQ-026 SHALL place the requester-id width function and the id typedef in shared package adder_3input_pkg.
REQ-027 SHALL implement grant selection in sub-module rr_arbiter (inputs request vector and pointer; outputs one-hot grant and encoded index).
REQ-028 SHALL implement the add as a combinational 3-input sum on the granted operands followed by LATENCY register stages carrying valid, id and data.

Verification
REQ-029 SHALL cover: NUM_REQ=4, only req 2 valid, operands 1,2,3 -> req_ready=0100 same cycle, out_valid after 2 cycles, out_id=2, out_data=6.
REQ-030 SHALL cover: all four requesters continuously valid from reset -> grants 0,1,2,3,0,1 on consecutive cycles, out_valid high every cycle from cycle 2.
REQ-031 SHALL cover: WIDTH=16, operands 0xFFFF,0xFFFF,0x0003 -> out_data=0x0001.
REQ-032 SHALL cover: requests 1 and 3 valid, pointer=2 -> grant 3, then 1, pointer wraps to 0 then 2.
REQ-033 SHALL cover: rst_n low one cycle after an accept (LATENCY=2) -> no out_valid for that request, outputs 0, pointer 0 after release.
REQ-034 SHALL cover: req 0 valid, then dropped before grant while req 1 granted -> exactly one result, out_id=1.
